// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the detector side (master) and the phase controller (slave).
// Carries per-phase demand in and the lamp drive / status back out.
interface traffic_light_ctrl_if #(
    parameter int NUM_PHASES = 4
);
    localparam int PW = $clog2(NUM_PHASES);

    logic [NUM_PHASES-1:0] req;
    logic                  flash_mode;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic [PW-1:0]         phase;
    logic [1:0]            state;

    modport master (
        output req, flash_mode,
        input  red, yellow, green, phase, state
    );

    modport slave (
        input  req, flash_mode,
        output red, yellow, green, phase, state
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Multi-phase round-robin intersection controller with demand skipping,
// actuated green extension, all-red clearance and night flash.
module traffic_light_ctrl #(
    parameter int NUM_PHASES     = 4,
    parameter int CNT_W          = 16,
    parameter int MIN_GREEN      = 10,
    parameter int MAX_GREEN      = 40,
    parameter int YELLOW_CYCLES  = 5,
    parameter int ALL_RED_CYCLES = 2,
    parameter int FLASH_HALF     = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  bus
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam logic [NUM_PHASES-1:0] ONE = NUM_PHASES'(1);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } st_t;

    st_t                   st, st_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [PW-1:0]         cur, cur_nxt, sel;
    logic [NUM_PHASES-1:0] pending, pend_nxt;
    logic                  flash_on, flash_nxt;
    logic [NUM_PHASES-1:0] red_q, yel_q, grn_q;
    logic [NUM_PHASES-1:0] red_nxt, yel_nxt, grn_nxt;
    logic [NUM_PHASES-1:0] cur_mask, nxt_mask;
    logic                  green_done;

    assign cur_mask = ONE << cur;
    assign nxt_mask = ONE << cur_nxt;

    // First pending phase after cur; plain cur+1 when nothing is waiting.
    always_comb begin
        sel = PW'((int'(cur) + 1) % NUM_PHASES);
        for (int i = NUM_PHASES; i >= 1; i--) begin
            logic [PW-1:0] pidx;
            pidx = PW'((int'(cur) + i) % NUM_PHASES);
            if (pending[pidx]) sel = pidx;
        end
    end

    assign green_done = (cnt >= CNT_W'(MIN_GREEN)) &&
                        ((cnt >= CNT_W'(MAX_GREEN)) ||
                         (|(pending & ~cur_mask)) ||
                         !(|(bus.req & cur_mask)) ||
                         bus.flash_mode);

    // cnt holds the 1-based cycle number within the current state.
    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt + 1'b1;
        cur_nxt   = cur;
        flash_nxt = flash_on;
        case (st)
            ST_ALL_RED: begin
                if (cnt >= CNT_W'(ALL_RED_CYCLES)) begin
                    cnt_nxt = CNT_W'(1);
                    if (bus.flash_mode) begin
                        st_nxt    = ST_FLASH;
                        flash_nxt = 1'b1;
                    end else begin
                        st_nxt  = ST_GREEN;
                        cur_nxt = sel;
                    end
                end
            end
            ST_GREEN: begin
                if (green_done) begin
                    st_nxt  = ST_YELLOW;
                    cnt_nxt = CNT_W'(1);
                end
            end
            ST_YELLOW: begin
                if (cnt >= CNT_W'(YELLOW_CYCLES)) begin
                    st_nxt  = ST_ALL_RED;
                    cnt_nxt = CNT_W'(1);
                end
            end
            default: begin
                if (!bus.flash_mode) begin
                    st_nxt  = ST_ALL_RED;
                    cnt_nxt = CNT_W'(1);
                end else if (cnt >= CNT_W'(FLASH_HALF)) begin
                    flash_nxt = ~flash_on;
                    cnt_nxt   = CNT_W'(1);
                end
            end
        endcase
    end

    // Demand for the served phase is swallowed for the whole green, including its grant edge.
    always_comb begin
        pend_nxt = pending | bus.req;
        if (st == ST_GREEN || st_nxt == ST_GREEN)
            pend_nxt = pend_nxt & ~nxt_mask;
    end

    always_comb begin
        red_nxt = '0;
        yel_nxt = '0;
        grn_nxt = '0;
        case (st_nxt)
            ST_ALL_RED: red_nxt = '1;
            ST_GREEN: begin
                grn_nxt = nxt_mask;
                red_nxt = ~nxt_mask;
            end
            ST_YELLOW: begin
                yel_nxt = nxt_mask;
                red_nxt = ~nxt_mask;
            end
            default: yel_nxt = {NUM_PHASES{flash_nxt}};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_ALL_RED;
            cnt      <= '0;
            cur      <= PW'(NUM_PHASES - 1);
            pending  <= '0;
            flash_on <= 1'b0;
            red_q    <= '1;
            yel_q    <= '0;
            grn_q    <= '0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            cur      <= cur_nxt;
            pending  <= pend_nxt;
            flash_on <= flash_nxt;
            red_q    <= red_nxt;
            yel_q    <= yel_nxt;
            grn_q    <= grn_nxt;
        end
    end

    assign bus.red    = red_q;
    assign bus.yellow = yel_q;
    assign bus.green  = grn_q;
    assign bus.phase  = cur;
    assign bus.state  = st;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed checks of the traffic light controller plus a random run with
// lamp-duration and safety monitoring.
module tb_traffic_light_ctrl;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    traffic_light_ctrl_if #(.NUM_PHASES(NP)) bus();

    traffic_light_ctrl #(
        .NUM_PHASES(NP), .CNT_W(16), .MIN_GREEN(10), .MAX_GREEN(20),
        .YELLOW_CYCLES(5), .ALL_RED_CYCLES(2), .FLASH_HALF(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {red, yellow, green}
    localparam logic [11:0] AR  = {4'hF, 4'h0, 4'h0};
    localparam logic [11:0] FON = {4'h0, 4'hF, 4'h0};
    localparam logic [11:0] FOF = {4'h0, 4'h0, 4'h0};

    function automatic logic [11:0] lg(int p);
        logic [3:0] m;
        m = 4'(1) << p;
        return {~m, 4'h0, m};
    endfunction

    function automatic logic [11:0] ly(int p);
        logic [3:0] m;
        m = 4'(1) << p;
        return {~m, m, 4'h0};
    endfunction

    function automatic logic [11:0] lamps();
        return {bus.red, bus.yellow, bus.green};
    endfunction

    task automatic run_chk(string tag, logic [11:0] exp, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, 32'(lamps()), 32'(exp));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.flash_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Random-phase monitor: safety every cycle, durations at each lamp change.
    int cls_prev = -1;
    int run_len  = 0;
    bit started  = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            int cls;
            logic ok;
            ok = ($countones(bus.green) <= 1) &&
                 (($countones(bus.yellow) <= 1) ||
                  (bus.yellow == 4'hF && bus.red == 4'h0 && bus.green == 4'h0));
            chk("safety", 32'(ok), 32'd1);
            if (bus.green != 0)                          cls = 1;
            else if (bus.red != 0 && bus.yellow != 0)    cls = 2;
            else if (bus.red == 4'hF)                    cls = 0;
            else                                         cls = 3;
            if (cls != cls_prev && cls_prev >= 0) begin
                if (started) begin
                    if (cls_prev == 1)
                        chk("green_len", 32'(run_len >= 10 && run_len <= 20), 32'd1);
                    else if (cls_prev == 2)
                        chk("yellow_len", 32'(run_len), 32'd5);
                    else if (cls_prev == 0)
                        chk("allred_len", 32'(run_len), 32'd2);
                end
                started = 1'b1;
                run_len = 0;
            end
            cls_prev = cls;
            run_len++;
        end
    end

    initial begin
        bus.req = '0;
        bus.flash_mode = 1'b0;

        // 1: reset values and fixed-time rotation
        repeat (2) @(negedge clk);
        chk("rst_red",    32'(bus.red),    32'hF);
        chk("rst_yellow", 32'(bus.yellow), 32'h0);
        chk("rst_green",  32'(bus.green),  32'h0);
        chk("rst_phase",  32'(bus.phase),  32'd3);
        chk("rst_state",  32'(bus.state),  32'd0);
        rst = 1'b0;
        run_chk("t1_ar", AR, 2);
        for (int p = 0; p < NP; p++) begin
            run_chk("t1_g", lg(p), 10);
            chk("t1_phase", 32'(bus.phase), 32'(p));
            run_chk("t1_y", ly(p), 5);
            run_chk("t1_ar", AR, 2);
        end
        run_chk("t1_wrap", lg(0), 1);
        chk("t1_wrap_phase", 32'(bus.phase), 32'd0);

        // 2: single-cycle demand skips idle phases
        do_reset();
        bus.req = 4'b0100;
        run_chk("t2_ar", AR, 1);
        bus.req = '0;
        run_chk("t2_ar", AR, 1);
        run_chk("t2_g2", lg(2), 10);
        chk("t2_phase", 32'(bus.phase), 32'd2);
        run_chk("t2_y2", ly(2), 1);

        // 3: extension to max, then early cut by competing demand
        do_reset();
        bus.req = 4'b0001;
        run_chk("t3_ar", AR, 2);
        run_chk("t3_gmax", lg(0), 20);
        run_chk("t3_y", ly(0), 1);
        chk("t3_state_y", 32'(bus.state), 32'd2);
        run_chk("t3_y", ly(0), 4);
        run_chk("t3_ar", AR, 2);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("t3_gcut", 32'(lamps()), 32'(lg(0)));
            if (k == 5) bus.req = 4'b1001;
            if (k == 6) bus.req = 4'b0001;
        end
        run_chk("t3_ycut", ly(0), 5);
        run_chk("t3_ar2", AR, 2);
        run_chk("t3_g3", lg(3), 1);
        chk("t3_phase", 32'(bus.phase), 32'd3);

        // 4: flash request during an extended green
        do_reset();
        bus.req = 4'b0001;
        run_chk("t4_ar", AR, 2);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("t4_g", 32'(lamps()), 32'(lg(0)));
            if (k == 12) bus.flash_mode = 1'b1;
        end
        run_chk("t4_y", ly(0), 5);
        run_chk("t4_ar", AR, 2);
        run_chk("t4_fon", FON, 3);
        chk("t4_state_f", 32'(bus.state), 32'd3);
        chk("t4_phase_f", 32'(bus.phase), 32'd0);
        run_chk("t4_foff", FOF, 3);
        run_chk("t4_fon2", FON, 3);
        bus.flash_mode = 1'b0;
        run_chk("t4_ar_exit", AR, 2);
        run_chk("t4_g_after", lg(0), 1);

        // 5: asynchronous reset pulse during yellow
        do_reset();
        run_chk("t5_ar", AR, 2);
        run_chk("t5_g0", lg(0), 10);
        run_chk("t5_y0", ly(0), 5);
        run_chk("t5_ar", AR, 2);
        run_chk("t5_g1", lg(1), 10);
        run_chk("t5_y1", ly(1), 2);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_lamps", 32'(lamps()), 32'(AR));
        chk("t5_async_phase", 32'(bus.phase), 32'd3);
        chk("t5_async_state", 32'(bus.state), 32'd0);
        rst = 1'b0;
        run_chk("t5_ar_re", AR, 2);
        run_chk("t5_g0_re", lg(0), 10);
        run_chk("t5_y0_re", ly(0), 1);

        // 6: random demand and flash with monitors
        do_reset();
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.req = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) bus.flash_mode = ~bus.flash_mode;
        end
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
